// File: rtl/present_pkg.sv
// -----------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT-80 decryptor:
//   - block/key/round sizes and round-counter constants
//   - FSM state enum and key-schedule mode enum
//   - forward and inverse S-box tables
//   - round-layer and key-schedule helper functions
// -----------------------------------------------------------------------------
package present_pkg;

    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;
    localparam int ROUNDS = 31;
    localparam int RC_W   = 5;
    localparam int RK_W   = 64;

    localparam logic [RC_W-1:0] RC_FIRST = 5'd1;
    localparam logic [RC_W-1:0] RC_LAST  = 5'd31;
    localparam logic [RC_W-1:0] RC_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2
    } state_e;

    // Key-schedule register operation requested by the top FSM each cycle.
    typedef enum logic [2:0] {
        KS_HOLD    = 3'd0,
        KS_LOAD    = 3'd1,
        KS_RESTORE = 3'd2,
        KS_FWD     = 3'd3,
        KS_INV     = 3'd4
    } ks_mode_e;

    // Nibble n of the packed constant is the substitution for input value n.
    localparam logic [15:0][3:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [15:0][3:0] INV_SBOX = 64'hA970364BD21C8FE5;

    // Destination of bit i under the forward permutation layer.
    function automatic int p_pos(input int i);
        int pos;
        if (i == 63) begin
            pos = 63;
        end else begin
            pos = (16 * i) % 63;
        end
        return pos;
    endfunction

    function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = 64'd0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = SBOX[x[4*n +: 4]];
        end
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = 64'd0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = INV_SBOX[x[4*n +: 4]];
        end
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) begin
            y[p_pos(i)] = x[i];
        end
        return y;
    endfunction

    // Pulls each bit back from where the forward layer would have sent it.
    function automatic logic [BLK_W-1:0] inv_p_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) begin
            y[i] = x[p_pos(i)];
        end
        return y;
    endfunction

    // Forward key update for round counter rc: rotate left 61, S-box the top
    // nibble, then fold the counter into bits 19:15.
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                 input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = SBOX[t[79:76]];
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_fwd for the same rc, steps undone in reverse order.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = INV_SBOX[t[79:76]];
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_key_sched.sv
// -----------------------------------------------------------------------------
// present_key_sched
// Owns the working key register K and the saved final key KL.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   mode_i         : operation applied to K this cycle (hold/load/restore/fwd/inv)
//   rc_i           : round counter used by the forward/inverse update
//   save_kl_i      : with KS_FWD, also capture the updated key into KL
//   key_i          : new key for KS_LOAD
//   round_key_o    : current round key, K[79:16]
// -----------------------------------------------------------------------------
module present_key_sched
    import present_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  ks_mode_e          mode_i,
    input  logic [RC_W-1:0]   rc_i,
    input  logic              save_kl_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic [RK_W-1:0]   round_key_o
);

    logic [KEY_W-1:0] k_q;
    logic [KEY_W-1:0] k_d;
    logic [KEY_W-1:0] kl_q;
    logic [KEY_W-1:0] kl_d;
    logic [KEY_W-1:0] fwd_s;

    assign fwd_s       = key_fwd(k_q, rc_i);
    assign round_key_o = k_q[79:16];

    // Next-key selection driven by the FSM mode.
    always_comb begin
        k_d  = k_q;
        kl_d = kl_q;
        case (mode_i)
            KS_HOLD: begin
                k_d = k_q;
            end
            KS_LOAD: begin
                k_d = key_i;
            end
            KS_RESTORE: begin
                k_d = kl_q;
            end
            KS_FWD: begin
                k_d = fwd_s;
                if (save_kl_i) begin
                    kl_d = fwd_s;
                end else begin
                    kl_d = kl_q;
                end
            end
            KS_INV: begin
                k_d = key_inv(k_q, rc_i);
            end
            default: begin
                k_d = k_q;
            end
        endcase
    end

    // Key and saved-final-key registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q  <= 80'd0;
            kl_q <= 80'd0;
        end else begin
            k_q  <= k_d;
            kl_q <= kl_d;
        end
    end

endmodule

// File: rtl/present_dec.sv
// -----------------------------------------------------------------------------
// present_dec
// PRESENT-80 block decryptor, one round per clock.
// A key load runs the forward schedule once (31 cycles) and saves the final
// round key; each decryption restores that key and walks the rounds backwards
// (32 cycles). A ciphertext strobed together with a key is parked and started
// as soon as the expansion finishes.
// Ports:
//   inClk, inRstN  : clock, asynchronous active-low reset
//   inKeyWr        : key load strobe, inKeyData sampled when accepted
//   inDataWr       : ciphertext strobe, inData sampled when accepted
//   outData        : registered plaintext of the last completed decryption
//   outBusy        : high during key expansion or decryption; strobes ignored
// -----------------------------------------------------------------------------
module present_dec
    import present_pkg::*;
(
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              inKeyWr,
    input  logic [KEY_W-1:0]  inKeyData,
    input  logic              inDataWr,
    input  logic [BLK_W-1:0]  inData,
    output logic [BLK_W-1:0]  outData,
    output logic              outBusy
);

    state_e            state_q, state_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [BLK_W-1:0]  s_q, s_d;
    logic [BLK_W-1:0]  p_q, p_d;
    logic              pending_q, pending_d;
    logic              key_valid_q, key_valid_d;
    logic [BLK_W-1:0]  out_data_q, out_data_d;
    logic              busy_q, busy_d;

    ks_mode_e          ks_mode_s;
    logic              save_kl_s;
    logic [RK_W-1:0]   round_key_s;

    present_key_sched u_key_sched (
        .clk_i       (inClk),
        .rst_ni      (inRstN),
        .mode_i      (ks_mode_s),
        .rc_i        (rc_q),
        .save_kl_i   (save_kl_s),
        .key_i       (inKeyData),
        .round_key_o (round_key_s)
    );

    // FSM next-state, datapath and key-schedule control.
    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        s_d         = s_q;
        p_d         = p_q;
        pending_d   = pending_q;
        key_valid_d = key_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        ks_mode_s   = KS_HOLD;
        save_kl_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (inKeyWr) begin
                    ks_mode_s = KS_LOAD;
                    rc_d      = RC_FIRST;
                    state_d   = KEYEXP;
                    busy_d    = 1'b1;
                    if (inDataWr) begin
                        p_d       = inData;
                        pending_d = 1'b1;
                    end else begin
                        pending_d = 1'b0;
                    end
                end else if (inDataWr && key_valid_q) begin
                    ks_mode_s = KS_RESTORE;
                    s_d       = inData;
                    rc_d      = RC_LAST;
                    state_d   = DEC;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end

            KEYEXP: begin
                ks_mode_s = KS_FWD;
                rc_d      = rc_q + 5'd1;
                if (rc_q == RC_LAST) begin
                    save_kl_s   = 1'b1;
                    key_valid_d = 1'b1;
                    // The schedule output is already the final key, so a
                    // parked ciphertext can start decrypting immediately.
                    if (pending_q) begin
                        s_d       = p_q;
                        pending_d = 1'b0;
                        rc_d      = RC_LAST;
                        state_d   = DEC;
                    end else begin
                        rc_d      = RC_ZERO;
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                    end
                end else begin
                    state_d = KEYEXP;
                end
            end

            DEC: begin
                if (rc_q != RC_ZERO) begin
                    s_d       = inv_sbox_layer(inv_p_layer(s_q ^ round_key_s));
                    ks_mode_s = KS_INV;
                    rc_d      = rc_q - 5'd1;
                    state_d   = DEC;
                end else begin
                    // Final whitening with the first round key; K is back
                    // to the loaded key at this point.
                    out_data_d = s_q ^ round_key_s;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                rc_d      = RC_ZERO;
                pending_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q     <= IDLE;
            rc_q        <= 5'd0;
            s_q         <= 64'd0;
            p_q         <= 64'd0;
            pending_q   <= 1'b0;
            key_valid_q <= 1'b0;
            out_data_q  <= 64'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            s_q         <= s_d;
            p_q         <= p_d;
            pending_q   <= pending_d;
            key_valid_q <= key_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign outData = out_data_q;
    assign outBusy = busy_q;

endmodule

// File: tb/tb_present_dec.sv
// -----------------------------------------------------------------------------
// tb_present_dec
// Self-checking bench for present_dec: published PRESENT-80 vectors, strobe
// rejection while busy, reset behaviour, and randomized round trips where a
// behavioural encryptor produces the ciphertext and the plaintext is expected.
// -----------------------------------------------------------------------------
module tb_present_dec;

    logic        inClk;
    logic        inRstN;
    logic        inKeyWr;
    logic [79:0] inKeyData;
    logic        inDataWr;
    logic [63:0] inData;
    logic [63:0] outData;
    logic        outBusy;

    int tests_run;
    int tests_failed;

    localparam int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    present_dec dut (
        .inClk     (inClk),
        .inRstN    (inRstN),
        .inKeyWr   (inKeyWr),
        .inKeyData (inKeyData),
        .inDataWr  (inDataWr),
        .inData    (inData),
        .outData   (outData),
        .outBusy   (outBusy)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    // Reference PRESENT-80 encryption straight from the round description.
    function automatic logic [63:0] model_encrypt(input logic [79:0] key,
                                                  input logic [63:0] pt);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = 4'(SB[s[4*n +: 4]]);
            for (int b = 0; b < 64; b++) s[(b == 63) ? 63 : (b * 16) % 63] = t[b];
            k = (k << 61) | (k >> 19);
            k[79:76] = 4'(SB[k[79:76]]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic strobe(input logic kw, input logic [79:0] k,
                          input logic dw, input logic [63:0] d);
        @(negedge inClk);
        inKeyWr   = kw;
        inKeyData = k;
        inDataWr  = dw;
        inData    = d;
        @(negedge inClk);
        inKeyWr   = 1'b0;
        inDataWr  = 1'b0;
    endtask

    // Counts busy cycles from the first negedge after the accepting edge.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (outBusy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge inClk);
        end
    endtask

    task automatic run_op(input string name, input logic kw, input logic [79:0] k,
                          input logic dw, input logic [63:0] d, input int exp_busy,
                          input logic chk_out, input logic [63:0] exp_out);
        int cnt;
        strobe(kw, k, dw, d);
        wait_idle(cnt);
        tests_run++;
        if (cnt !== exp_busy) begin
            tests_failed++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, cnt, exp_busy);
        end
        if (chk_out) begin
            tests_run++;
            if (outData !== exp_out) begin
                tests_failed++;
                $display("FAIL %s out: got %h expected %h", name, outData, exp_out);
            end
        end
    endtask

    task automatic apply_reset();
        inRstN = 1'b0;
        repeat (3) @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (outBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", outBusy);
        end
        tests_run++;
        if (outData !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_out: got %h expected 0", outData);
        end
    endtask

    task automatic test_no_key();
        apply_reset();
        strobe(1'b0, 80'd0, 1'b1, 64'h5579C1387B228445);
        repeat (3) @(negedge inClk);
        tests_run++;
        if (outBusy !== 1'b0 || outData !== 64'd0) begin
            tests_failed++;
            $display("FAIL no_key: busy %b out %h expected busy 0 out 0", outBusy, outData);
        end
    endtask

    task automatic test_vectors();
        run_op("tp1_key0_ct", 1'b1, 80'd0, 1'b1, 64'h5579C1387B228445, 63, 1'b1, 64'd0);
        run_op("tp2_keyF_ct", 1'b1, {80{1'b1}}, 1'b1, 64'hE72C46C0F5945049, 63, 1'b1, 64'd0);
        run_op("tp2_data", 1'b0, 80'd0, 1'b1, 64'h3333DCD3213210D2, 32, 1'b1, {64{1'b1}});
        // Key load alone must not disturb the last plaintext.
        run_op("tp3_key", 1'b1, 80'd0, 1'b0, 64'd0, 31, 1'b1, {64{1'b1}});
        run_op("tp3_data", 1'b0, 80'd0, 1'b1, 64'hA112FFC72F68417B, 32, 1'b1, {64{1'b1}});
        run_op("tp3_repeat", 1'b0, 80'd0, 1'b1, 64'hA112FFC72F68417B, 32, 1'b1, {64{1'b1}});
    endtask

    // Fires both strobes at busy cycle pulse_at while a decryption runs.
    task automatic dec_with_pulse(input string name, input int pulse_at);
        int cnt;
        strobe(1'b0, 80'd0, 1'b1, 64'h3333DCD3213210D2);
        cnt = 0;
        while (outBusy === 1'b1 && cnt < 200) begin
            cnt++;
            inKeyWr   = (cnt == pulse_at);
            inDataWr  = (cnt == pulse_at);
            inKeyData = 80'h0123456789ABCDEF0123;
            inData    = 64'hA112FFC72F68417B;
            @(negedge inClk);
        end
        inKeyWr  = 1'b0;
        inDataWr = 1'b0;
        tests_run++;
        if (cnt !== 32) begin
            tests_failed++;
            $display("FAIL %s busy_len: got %0d expected 32", name, cnt);
        end
        repeat (2) @(negedge inClk);
        tests_run++;
        if (outBusy !== 1'b0 || outData !== {64{1'b1}}) begin
            tests_failed++;
            $display("FAIL %s after: busy %b out %h expected busy 0 out ffffffffffffffff",
                     name, outBusy, outData);
        end
    endtask

    task automatic test_ignore_strobes();
        run_op("ign_key", 1'b1, {80{1'b1}}, 1'b0, 64'd0, 31, 1'b0, 64'd0);
        dec_with_pulse("ign_mid", 10);
        dec_with_pulse("ign_fall", 32);
    endtask

    task automatic test_random_roundtrip();
        logic [79:0] base;
        logic [79:0] key;
        logic [63:0] pt;
        logic [63:0] ct;
        base = {$urandom(), $urandom(), 16'($urandom())};
        pt   = {$urandom(), $urandom()};
        for (int i = 0; i < 11; i++) begin
            key = base ^ 80'(i);
            ct  = model_encrypt(key, pt);
            if (i % 2 == 0) begin
                run_op($sformatf("rnd%0d_both", i), 1'b1, key, 1'b1, ct, 63, 1'b1, pt);
            end else begin
                run_op($sformatf("rnd%0d_key", i), 1'b1, key, 1'b0, 64'd0, 31, 1'b0, 64'd0);
                run_op($sformatf("rnd%0d_data", i), 1'b0, 80'd0, 1'b1, ct, 32, 1'b1, pt);
            end
            pt = ct;
        end
    endtask

    task automatic test_reset_mid_dec();
        int cnt;
        run_op("rst_pre", 1'b1, {80{1'b1}}, 1'b1, 64'hE72C46C0F5945049, 63, 1'b0, 64'd0);
        run_op("rst_pre2", 1'b0, 80'd0, 1'b1, 64'h3333DCD3213210D2, 32, 1'b1, {64{1'b1}});
        strobe(1'b0, 80'd0, 1'b1, 64'h3333DCD3213210D2);
        repeat (9) @(negedge inClk);
        #2;
        inRstN = 1'b0;
        #1;
        tests_run++;
        if (outBusy !== 1'b0 || outData !== 64'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: busy %b out %h expected busy 0 out 0", outBusy, outData);
        end
        @(negedge inClk);
        inRstN = 1'b1;
        // Key must be reloaded after reset: a lone ciphertext is dropped.
        strobe(1'b0, 80'd0, 1'b1, 64'h3333DCD3213210D2);
        wait_idle(cnt);
        tests_run++;
        if (cnt !== 0) begin
            tests_failed++;
            $display("FAIL rst_keyvalid: busy_len %0d expected 0", cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        inRstN       = 1'b0;
        inKeyWr      = 1'b0;
        inKeyData    = 80'd0;
        inDataWr     = 1'b0;
        inData       = 64'd0;
        test_reset();
        test_vectors();
        test_ignore_strobes();
        test_no_key();
        test_random_roundtrip();
        test_reset_mid_dec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/present_dec.md
Name: present_dec

Overview:
PRESENT-80 block decryptor: the inverse of the existing PresentEnc core, with the same load/busy interface style.
- Takes an 80-bit key and a 64-bit ciphertext and returns the 64-bit plaintext.
- One round per clock.
- Expands the key forward once per key load to obtain the final round key, then runs the 31 rounds in reverse.
- Sits beside PresentEnc so the same link can encrypt and decrypt.

Parameters:
KEY_W, 80, key width (fixed by PRESENT-80)
BLK_W, 64, block width
ROUNDS, 31, cipher round count

Ports:
inClk  in  1  rising-edge clock
inRstN  in  1  asynchronous active-low reset
inKeyWr  in  1  key load strobe, one cycle
inKeyData  in  80  key, sampled when inKeyWr=1 and accepted
inDataWr  in  1  ciphertext load strobe, one cycle
inData  in  64  ciphertext, sampled when inDataWr=1 and accepted
outData  out  64  plaintext, registered, valid while outBusy=0 after a decryption
outBusy  out  1  high while key expansion or decryption is in progress

Behaviour:
- Clock and reset: one clock, inClk. Reset is inRstN, asynchronous and active-low.
- Reset values:
  - outData=0, outBusy=0, state=IDLE.
  - keyValid=0, pending=0, all internal registers 0.
- Internal registers:
  - key register K[79:0].
  - saved final key KL[79:0].
  - state S[63:0].
  - round counter rc[4:0].
  - pending flag and pending ciphertext P[63:0].
- Round key is K[79:16].
- Forward key update, for i=1..31: K←rotl(K,61); K[79:76]←Sbox(K[79:76]); K[19:15]^=i.
- Inverse key update for i: K[19:15]^=i; K[79:76]←InvSbox(K[79:76]); K←rotr(K,61).
- States:
  - IDLE:
    - inKeyWr=1: K←inKeyData, rc←1, go KEYEXP, outBusy←1.
    - inDataWr=1 in the same cycle: P←inData, pending←1.
    - inDataWr=1 alone with keyValid=1: K←KL, S←inData, rc←31, go DEC, outBusy←1.
    - inDataWr=1 alone with keyValid=0: ignored.
  - KEYEXP, 31 cycles, rc=1..31:
    - Each cycle K←fwdUpdate(K,rc), rc++.
    - On the rc=31 cycle: KL←fwdUpdate result, keyValid←1.
    - Then with pending=1: K←that result, S←P, pending←0, rc←31, go DEC.
    - Otherwise go IDLE, outBusy←0.
  - DEC, 32 cycles:
    - For rc=31 down to 1: S←InvS(InvP(S ^ K[79:16])); K←invUpdate(K,rc); rc--.
    - On the rc=0 cycle: outData←S ^ K[79:16], outBusy←0, go IDLE.
    - K then equals the original key.
- Latency, counted from the accepting edge:
  - Data only: outBusy high for exactly 32 cycles.
  - Key only: 31 cycles.
  - Key+data together: 63 cycles.
- Strobes while outBusy=1 (inKeyWr or inDataWr) are ignored, with no queuing. This includes a strobe in the very cycle outBusy falls, since outBusy is still registered high then.
- outData holds its last value until the next decryption completes. It is not cleared by a key load.
- Reset mid-operation aborts immediately. Reset clears keyValid, so a key must be reloaded.
- InvP: bit j of the input moves to position i, where P(i)=j, with P(i)=16·i mod 63 for i<63 and P(63)=63.

Decomposition:
- Package present_pkg:
  - SBOX and INV_SBOX 16×4 constants.
  - Functions sbox_layer, inv_sbox_layer, p_layer, inv_p_layer, key_fwd, key_inv.
  - KEY_W/BLK_W/ROUNDS localparams.
  - State enum {IDLE, KEYEXP, DEC}.
- Sub-module present_key_sched: owns K and KL, rc-driven forward/inverse update, controlled by mode inputs from the top FSM.
- Datapath and FSM stay in present_dec.

Test Plan:
1. Reset, then key=0 + ct=5579C1387B228445 strobed together -> outBusy high 63 cycles; outData=0000000000000000.
2. Key=FFFF_FFFFFFFF_FFFFFFFF, ct=E72C46C0F5945049 together -> outData=0000000000000000. Then data-only ct=3333DCD3213210D2 -> busy 32 cycles; outData=FFFFFFFFFFFFFFFF.
3. Key=0 loaded alone (busy 31), then ct=A112FFC72F68417B -> busy 32; outData=FFFFFFFFFFFFFFFF. Repeat the same ct -> same result (KL reused, no re-expansion).
4. inDataWr or inKeyWr pulsed at DEC cycle 10 -> ignored; result and busy length unchanged.
5. inDataWr after reset with no key -> outBusy stays 0; outData stays 0.
6. Closed loop with PresentEnc: 11 chained ciphertexts (key ^= index, as in the encryptor bench) fed back -> each plaintext matches the encryptor input. Also assert inRstN low mid-DEC -> outBusy=0 and outData=0 immediately.
